// File: rtl/rvh_l1d_cc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rvh_l1d_cc_pkg
// Purpose : Shared cache <-> SCU coherence channel types and constants used by
//           the L1D EWRQ-to-SCU writeback arbiter and its neighbours.
// Contents: cache_id_t, cache_scu_cc_req_t, cache_scu_cc_data_t,
//           cache_scu_cc_resp_t, request/response type enums, width constants.
// Revision: 1.0 - initial release
// ============================================================================
package rvh_l1d_cc_pkg;

  // Master id: msb set marks the instruction cache, the low BID_W bits carry
  // the L1D bank number.
  localparam int CACHE_MASTERID_W = 3;
  localparam int BID_W            = CACHE_MASTERID_W - 1;
  localparam int TID_W            = 2;
  localparam int PADDR_W          = 32;
  localparam int LINE_DATA_W      = 64;

  typedef enum logic [1:0] {
    Evict     = 2'd0,
    WriteBack = 2'd1
  } cc_req_type_e;

  typedef enum logic [1:0] {
    WriteBack_Ack = 2'd0,
    Comp          = 2'd1
  } cc_resp_type_e;

  typedef struct packed {
    logic [CACHE_MASTERID_W-1:0] bid;
    logic [TID_W-1:0]            tid;
  } cache_id_t;

  typedef struct packed {
    cache_id_t          id;
    cc_req_type_e       rtype;
    logic [PADDR_W-1:0] paddr;
  } cache_scu_cc_req_t;

  typedef struct packed {
    cache_id_t              id;
    logic [LINE_DATA_W-1:0] data;
  } cache_scu_cc_data_t;

  typedef struct packed {
    cache_id_t     id;
    cc_resp_type_e rtype;
  } cache_scu_cc_resp_t;

  // True when the id belongs to the instruction cache rather than an L1D bank.
  function automatic logic bid_is_icache(input cache_id_t id);
    return id.bid[CACHE_MASTERID_W-1];
  endfunction

endpackage : rvh_l1d_cc_pkg
`default_nettype wire

// File: rtl/rvh_l1d_ewrq_scu_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : rvh_l1d_ewrq_scu_arb_if
// Purpose : Bundles the per-bank EWRQ channels and the single SCU channel
//           pair handled by rvh_l1d_ewrq_scu_arb.
// Ports   : bank_evict_*  per-bank evict request handshake
//           bank_data_*   per-bank writeback data handshake
//           bank_resp_*   SCU response routed back to banks
//           pc_scu_*      evict/data toward SCU
//           scu_pc_resp_* response from SCU
// Modports: slave  - the arbiter
//           master - the environment around it (EWRQs + SCU)
// Revision: 1.0 - initial release
// ============================================================================
interface rvh_l1d_ewrq_scu_arb_if
  import rvh_l1d_cc_pkg::*;
#(
  parameter int N_BANK = 2
) ();

  logic               [N_BANK-1:0] bank_evict_vld_i;
  cache_scu_cc_req_t  [N_BANK-1:0] bank_evict_i;
  logic               [N_BANK-1:0] bank_evict_rdy_o;

  logic               [N_BANK-1:0] bank_data_vld_i;
  cache_scu_cc_data_t [N_BANK-1:0] bank_data_i;
  logic               [N_BANK-1:0] bank_data_rdy_o;

  logic               [N_BANK-1:0] bank_resp_vld_o;
  cache_scu_cc_resp_t              bank_resp_o;
  logic               [N_BANK-1:0] bank_resp_rdy_i;

  logic                            pc_scu_evict_vld_o;
  cache_scu_cc_req_t               pc_scu_evict_o;
  logic                            pc_scu_evict_rdy_i;

  logic                            pc_scu_data_vld_o;
  cache_scu_cc_data_t              pc_scu_data_o;
  logic                            pc_scu_data_rdy_i;

  logic                            scu_pc_resp_vld_i;
  cache_scu_cc_resp_t              scu_pc_resp_i;
  logic                            scu_pc_resp_rdy_o;

  modport slave (
    input  bank_evict_vld_i, bank_evict_i,
    output bank_evict_rdy_o,
    input  bank_data_vld_i, bank_data_i,
    output bank_data_rdy_o,
    output bank_resp_vld_o, bank_resp_o,
    input  bank_resp_rdy_i,
    output pc_scu_evict_vld_o, pc_scu_evict_o,
    input  pc_scu_evict_rdy_i,
    output pc_scu_data_vld_o, pc_scu_data_o,
    input  pc_scu_data_rdy_i,
    input  scu_pc_resp_vld_i, scu_pc_resp_i,
    output scu_pc_resp_rdy_o
  );

  modport master (
    output bank_evict_vld_i, bank_evict_i,
    input  bank_evict_rdy_o,
    output bank_data_vld_i, bank_data_i,
    input  bank_data_rdy_o,
    input  bank_resp_vld_o, bank_resp_o,
    output bank_resp_rdy_i,
    input  pc_scu_evict_vld_o, pc_scu_evict_o,
    output pc_scu_evict_rdy_i,
    input  pc_scu_data_vld_o, pc_scu_data_o,
    output pc_scu_data_rdy_i,
    output scu_pc_resp_vld_i, scu_pc_resp_i,
    input  scu_pc_resp_rdy_o
  );

endinterface : rvh_l1d_ewrq_scu_arb_if
`default_nettype wire

// File: rtl/rvh_l1d_rr_lock_arb.sv
`default_nettype none
// ============================================================================
// Module  : rvh_l1d_rr_lock_arb
// Purpose : Round-robin arbiter with grant locking. Once a grant is presented
//           downstream and not accepted, it is held until the handshake.
// Ports   : clk, rst       clock, async active-high reset
//           req_i [N]      eligible requesters (used when not locked)
//           vld_i [N]      raw valids (the locked requester is tracked by this)
//           rdy_i          downstream ready
//           gnt_o [N]      one-hot grant
//           gnt_idx_o      grant index
//           gnt_vld_o      a grant is presented downstream
//           hs_o           handshake pulse (gnt_vld_o & rdy_i)
// Revision: 1.0 - initial release
// ============================================================================
module rvh_l1d_rr_lock_arb #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     vld_i,
  input  logic             rdy_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o,
  output logic             hs_o
);

  logic [IDX_W-1:0] rr_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] rr_nxt;

  // Scan from the farthest offset down to offset 0 so the requester closest
  // to rr_q is the last one written, i.e. the winner.
  always_comb begin
    pick_idx = rr_q;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = IDX_W'((int'(rr_q) + k) % N);
      if (req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // A locked grant ignores eligibility masking and follows the raw valid.
  always_comb begin
    if (lock_q) begin
      gnt_idx_o = lock_idx_q;
      gnt_vld_o = vld_i[lock_idx_q] & ~rst;
    end else begin
      gnt_idx_o = pick_idx;
      gnt_vld_o = pick_vld & ~rst;
    end
    hs_o = gnt_vld_o & rdy_i;
    for (int b = 0; b < N; b++) begin
      gnt_o[b] = gnt_vld_o & (gnt_idx_o == IDX_W'(b));
    end
  end

  assign rr_nxt = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs_o) begin
      rr_q   <= rr_nxt;
      lock_q <= 1'b0;
    end else if (gnt_vld_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx_o;
    end
  end

endmodule : rvh_l1d_rr_lock_arb
`default_nettype wire

// File: rtl/rvh_l1d_ewrq_scu_arb.sv
`default_nettype none
// ============================================================================
// Module  : rvh_l1d_ewrq_scu_arb
// Purpose : Shares the single private-cache -> SCU evict/writeback channel
//           pair among N_BANK L1D EWRQs, routes SCU responses back by bank
//           id, tracks per-bank outstanding evicts and flags protocol errors.
// Ports   : clk, rst        clock, async active-high reset
//           bus (slave)     bank-side and SCU-side handshakes
//           outstanding_o   per-bank outstanding evict count
//           proto_err_o     sticky protocol-error flag
// Revision: 1.0 - initial release
// ============================================================================
module rvh_l1d_ewrq_scu_arb
  import rvh_l1d_cc_pkg::*;
#(
  parameter int N_BANK  = 2,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  rvh_l1d_ewrq_scu_arb_if.slave         bus,
  output logic [N_BANK-1:0][CNT_W-1:0]  outstanding_o,
  output logic                          proto_err_o
);

  localparam int IDX_W = $clog2(N_BANK);

  logic [N_BANK-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                         proto_err_q, proto_err_d;

  logic [N_BANK-1:0] ev_req;
  logic [N_BANK-1:0] ev_gnt;
  logic [IDX_W-1:0]  ev_idx;
  logic              ev_vld;
  logic              ev_hs;

  logic [N_BANK-1:0] dat_gnt;
  logic [IDX_W-1:0]  dat_idx;
  logic              dat_vld;
  logic              dat_hs;

  logic [BID_W-1:0]  resp_tgt;
  logic              resp_bad;
  logic [N_BANK-1:0] resp_sel;
  logic              resp_hs;
  logic              resp_is_ack;
  logic [N_BANK-1:0] ev_inc;
  logic [N_BANK-1:0] ack_dec;

  // ---------------- evict channel ----------------
  // A bank at its credit limit cannot win a fresh grant.
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      ev_req[b] = bus.bank_evict_vld_i[b] & (cnt_q[b] < CNT_W'(MAX_OUT));
    end
  end

  rvh_l1d_rr_lock_arb #(.N(N_BANK), .IDX_W(IDX_W)) u_ev_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (ev_req),
    .vld_i     (bus.bank_evict_vld_i),
    .rdy_i     (bus.pc_scu_evict_rdy_i),
    .gnt_o     (ev_gnt),
    .gnt_idx_o (ev_idx),
    .gnt_vld_o (ev_vld),
    .hs_o      (ev_hs)
  );

  assign bus.pc_scu_evict_vld_o = ev_vld;
  assign bus.pc_scu_evict_o     = bus.bank_evict_i[ev_idx];
  assign bus.bank_evict_rdy_o   = ev_gnt & {N_BANK{bus.pc_scu_evict_rdy_i}};

  // ---------------- data channel ----------------
  rvh_l1d_rr_lock_arb #(.N(N_BANK), .IDX_W(IDX_W)) u_dat_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.bank_data_vld_i),
    .vld_i     (bus.bank_data_vld_i),
    .rdy_i     (bus.pc_scu_data_rdy_i),
    .gnt_o     (dat_gnt),
    .gnt_idx_o (dat_idx),
    .gnt_vld_o (dat_vld),
    .hs_o      (dat_hs)
  );

  assign bus.pc_scu_data_vld_o = dat_vld;
  assign bus.pc_scu_data_o     = bus.bank_data_i[dat_idx];
  assign bus.bank_data_rdy_o   = dat_gnt & {N_BANK{bus.pc_scu_data_rdy_i}};

  // ---------------- response routing ----------------
  // Responses for the I$ or a nonexistent bank are swallowed so the SCU
  // never stalls on them; they only raise the error flag.
  always_comb begin
    resp_tgt = bus.scu_pc_resp_i.id.bid[BID_W-1:0];
    resp_bad = bid_is_icache(bus.scu_pc_resp_i.id) | (int'(resp_tgt) >= N_BANK);
    for (int b = 0; b < N_BANK; b++) begin
      resp_sel[b] = (int'(resp_tgt) == b);
    end
  end

  assign bus.bank_resp_vld_o   = resp_sel & {N_BANK{bus.scu_pc_resp_vld_i & ~resp_bad & ~rst}};
  assign bus.bank_resp_o       = bus.scu_pc_resp_i;
  assign bus.scu_pc_resp_rdy_o = ~rst & (resp_bad | (|(resp_sel & bus.bank_resp_rdy_i)));
  assign resp_hs               = bus.scu_pc_resp_vld_i & bus.scu_pc_resp_rdy_o;
  assign resp_is_ack           = (bus.scu_pc_resp_i.rtype == WriteBack_Ack);

  // ---------------- outstanding counters ----------------
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      ev_inc[b]  = ev_hs & (ev_idx == IDX_W'(b));
      ack_dec[b] = resp_hs & ~resp_bad & resp_is_ack & resp_sel[b];
    end
  end

  // Counters saturate at both ends; an over/underflow attempt is an error.
  always_comb begin
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
    if (resp_hs & resp_bad) begin
      proto_err_d = 1'b1;
    end
    for (int b = 0; b < N_BANK; b++) begin
      if (ev_inc[b] & ~ack_dec[b]) begin
        if (cnt_q[b] == CNT_W'(MAX_OUT)) begin
          proto_err_d = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end else if (ack_dec[b] & ~ev_inc[b]) begin
        if (cnt_q[b] == '0) begin
          proto_err_d = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign proto_err_o   = proto_err_q;

endmodule : rvh_l1d_ewrq_scu_arb
`default_nettype wire

// File: tb/tb_rvh_l1d_ewrq_scu_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rvh_l1d_ewrq_scu_arb
// Purpose : Directed self-checking bench for rvh_l1d_ewrq_scu_arb
//           (N_BANK=2, MAX_OUT=2). Expected grant order is queued when
//           stimulus is driven and popped when the SCU side handshakes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rvh_l1d_ewrq_scu_arb;
  import rvh_l1d_cc_pkg::*;

  localparam int N_BANK  = 2;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_BANK-1:0][CNT_W-1:0] outstanding;
  logic proto_err;

  int n_chk = 0;
  int n_err = 0;
  int ev_q[$];
  int dat_q[$];
  int m_cnt[N_BANK];

  rvh_l1d_ewrq_scu_arb_if #(.N_BANK(N_BANK)) bus ();

  rvh_l1d_ewrq_scu_arb #(.N_BANK(N_BANK), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .outstanding_o (outstanding),
    .proto_err_o   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [3:0] m_pack();
    return {CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])};
  endfunction

  task automatic m_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic drive_resp(input logic v, input logic [2:0] bid,
                            input cc_resp_type_e rt, input logic [1:0] brdy);
    bus.scu_pc_resp_vld_i      = v;
    bus.scu_pc_resp_i.id.bid   = bid;
    bus.scu_pc_resp_i.id.tid   = '0;
    bus.scu_pc_resp_i.rtype    = rt;
    bus.bank_resp_rdy_i        = brdy;
  endtask

  // Pops the expected evict winner and checks the SCU-side handshake.
  task automatic ev_observe(input string tag);
    int e;
    chk({tag, "_ev_vld"}, bus.pc_scu_evict_vld_o, 1);
    if (bus.pc_scu_evict_vld_o === 1'b1 && bus.pc_scu_evict_rdy_i === 1'b1 && ev_q.size() > 0) begin
      e = ev_q.pop_front();
      chk({tag, "_ev_bid"},   bus.pc_scu_evict_o.id.bid, e);
      chk({tag, "_ev_paddr"}, bus.pc_scu_evict_o.paddr, 32'h1000 + 32'(e) * 32'h40);
      chk({tag, "_ev_rdy"},   bus.bank_evict_rdy_o, 2'b01 << e);
      m_cnt[e]++;
    end
  endtask

  task automatic dat_observe(input string tag);
    int e;
    chk({tag, "_dat_vld"}, bus.pc_scu_data_vld_o, 1);
    if (bus.pc_scu_data_vld_o === 1'b1 && bus.pc_scu_data_rdy_i === 1'b1 && dat_q.size() > 0) begin
      e = dat_q.pop_front();
      chk({tag, "_dat_data"}, bus.pc_scu_data_o.data, 64'hDA7A_0000 + 64'(e));
      chk({tag, "_dat_rdy"},  bus.bank_data_rdy_o, 2'b01 << e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    for (int b = 0; b < N_BANK; b++) begin
      bus.bank_evict_i[b].id.bid = 3'(b);
      bus.bank_evict_i[b].id.tid = '0;
      bus.bank_evict_i[b].rtype  = WriteBack;
      bus.bank_evict_i[b].paddr  = 32'h1000 + 32'(b) * 32'h40;
      bus.bank_data_i[b].id.bid  = 3'(b);
      bus.bank_data_i[b].id.tid  = '0;
      bus.bank_data_i[b].data    = 64'hDA7A_0000 + 64'(b);
    end

    // ---- reset: every handshake output held low even with traffic present
    bus.bank_evict_vld_i   = 2'b11;
    bus.pc_scu_evict_rdy_i = 1'b1;
    bus.bank_data_vld_i    = 2'b11;
    bus.pc_scu_data_rdy_i  = 1'b1;
    drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
    #2;
    chk("rst_ev_vld",   bus.pc_scu_evict_vld_o, 0);
    chk("rst_ev_rdy",   bus.bank_evict_rdy_o, 0);
    chk("rst_dat_vld",  bus.pc_scu_data_vld_o, 0);
    chk("rst_dat_rdy",  bus.bank_data_rdy_o, 0);
    chk("rst_resp_vld", bus.bank_resp_vld_o, 0);
    chk("rst_resp_rdy", bus.scu_pc_resp_rdy_o, 0);
    chk("rst_cnt",      outstanding, 0);
    chk("rst_err",      proto_err, 0);
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b00);
    tick();
    rst = 1'b0;

    // ---- two-bank contention on both channels: 0,1,0
    ev_q.push_back(0);  ev_q.push_back(1);  ev_q.push_back(0);
    dat_q.push_back(0); dat_q.push_back(1); dat_q.push_back(0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("cont%0d_cnt", i), outstanding, m_pack());
      ev_observe($sformatf("cont%0d", i));
      dat_observe($sformatf("cont%0d", i));
      tick();
    end
    bus.bank_data_vld_i = 2'b00;

    // ---- credit limit: bank0 at MAX_OUT is masked; ack in the same cycle
    bus.bank_evict_vld_i = 2'b01;
    drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
    settle();
    chk("credit_cnt",      outstanding, m_pack());
    chk("credit_ev_vld",   bus.pc_scu_evict_vld_o, 0);
    chk("credit_ev_rdy",   bus.bank_evict_rdy_o, 0);
    chk("credit_resp_vld", bus.bank_resp_vld_o, 2'b01);
    chk("credit_resp_rdy", bus.scu_pc_resp_rdy_o, 1);
    m_cnt[0]--;
    tick();
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b11);
    ev_q.push_back(0);
    settle();
    chk("reelig_cnt", outstanding, m_pack());
    ev_observe("reelig");
    tick();
    bus.bank_evict_vld_i = 2'b00;

    // ---- response routing: bid=1 waits for bank1 ready
    drive_resp(1'b1, 3'd1, WriteBack_Ack, 2'b01);
    settle();
    chk("route_vld",  bus.bank_resp_vld_o, 2'b10);
    chk("route_rdy0", bus.scu_pc_resp_rdy_o, 0);
    chk("route_bid",  bus.bank_resp_o.id.bid, 3'd1);
    tick();
    chk("route_hold_cnt", outstanding, m_pack());
    chk("route_hold_vld", bus.bank_resp_vld_o, 2'b10);
    bus.bank_resp_rdy_i = 2'b11;
    settle();
    chk("route_rdy1", bus.scu_pc_resp_rdy_o, 1);
    m_cnt[1]--;
    tick();
    // non-ack response is routed but leaves the counter alone
    drive_resp(1'b1, 3'd0, Comp, 2'b11);
    settle();
    chk("comp_vld", bus.bank_resp_vld_o, 2'b01);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
      settle();
      chk($sformatf("drain%0d_cnt", i), outstanding, m_pack());
      m_cnt[0]--;
      tick();
    end
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b11);
    settle();
    chk("drain_cnt", outstanding, 0);
    chk("drain_err", proto_err, 0);

    // ---- I$ response: consumed, not routed, sets error
    drive_resp(1'b1, 3'b100, WriteBack_Ack, 2'b00);
    settle();
    chk("icache_vld", bus.bank_resp_vld_o, 2'b00);
    chk("icache_rdy", bus.scu_pc_resp_rdy_o, 1);
    chk("icache_err_pre", proto_err, 0);
    tick();
    drive_resp(1'b1, 3'b011, WriteBack_Ack, 2'b00);
    settle();
    chk("icache_err", proto_err, 1);
    chk("oor_vld", bus.bank_resp_vld_o, 2'b00);
    chk("oor_rdy", bus.scu_pc_resp_rdy_o, 1);
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b00);
    rst = 1'b1;
    settle();
    chk("err_clr", proto_err, 0);
    tick();
    rst = 1'b0;

    // ---- ack with no outstanding evict
    drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
    settle();
    chk("underflow_rdy", bus.scu_pc_resp_rdy_o, 1);
    tick();
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b11);
    settle();
    chk("underflow_err", proto_err, 1);
    chk("underflow_cnt", outstanding, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_reset();

    // ---- grant lock: bank1 held while SCU stalls
    bus.pc_scu_evict_rdy_i = 1'b0;
    bus.bank_evict_vld_i   = 2'b10;
    settle();
    chk("lock1_bid", bus.pc_scu_evict_o.id.bid, 3'd1);
    chk("lock1_rdy", bus.bank_evict_rdy_o, 2'b00);
    tick();
    bus.bank_evict_vld_i = 2'b11;
    settle();
    chk("lock2_bid", bus.pc_scu_evict_o.id.bid, 3'd1);
    tick();
    settle();
    chk("lock3_bid", bus.pc_scu_evict_o.id.bid, 3'd1);
    tick();
    bus.pc_scu_evict_rdy_i = 1'b1;
    ev_q.push_back(1);
    settle();
    ev_observe("lock4");
    tick();
    ev_q.push_back(0);
    settle();
    ev_observe("lock5");
    tick();
    bus.bank_evict_vld_i = 2'b00;

    // ---- simultaneous increment and ack on bank0
    bus.bank_evict_vld_i = 2'b01;
    drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
    ev_q.push_back(0);
    settle();
    ev_observe("simul");
    chk("simul_resp_rdy", bus.scu_pc_resp_rdy_o, 1);
    m_cnt[0]--;
    tick();
    bus.bank_evict_vld_i = 2'b00;
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b11);
    settle();
    chk("simul_cnt", outstanding, m_pack());
    chk("simul_err", proto_err, 0);

    // ---- async reset in the middle of a locked grant
    bus.pc_scu_evict_rdy_i = 1'b0;
    bus.bank_evict_vld_i   = 2'b10;
    tick();
    bus.bank_evict_vld_i = 2'b11;
    bus.bank_data_vld_i  = 2'b11;
    drive_resp(1'b1, 3'd0, WriteBack_Ack, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_ev_vld",   bus.pc_scu_evict_vld_o, 0);
    chk("arst_ev_rdy",   bus.bank_evict_rdy_o, 0);
    chk("arst_dat_vld",  bus.pc_scu_data_vld_o, 0);
    chk("arst_resp_vld", bus.bank_resp_vld_o, 0);
    chk("arst_resp_rdy", bus.scu_pc_resp_rdy_o, 0);
    chk("arst_cnt",      outstanding, m_pack());
    bus.bank_data_vld_i = 2'b00;
    drive_resp(1'b0, 3'd0, WriteBack_Ack, 2'b00);
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_bid", bus.pc_scu_evict_o.id.bid, 3'd0);
    bus.pc_scu_evict_rdy_i = 1'b1;
    ev_q.push_back(0);
    settle();
    ev_observe("post_rst");
    tick();
    bus.bank_evict_vld_i = 2'b00;

    chk("ev_q_empty",  ev_q.size(), 0);
    chk("dat_q_empty", dat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_rvh_l1d_ewrq_scu_arb
`default_nettype wire
